key_event_decoder: RTL and testbench
====================================

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter LONG_TICKS, default 200, held ticks for a long press (2 s at 100 Hz).
REQ-003 SHALL have parameter REPEAT_TICKS, default 20, ticks between auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  system clock; the block uses only this clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_tick  input  1  one-clk-wide 100 Hz strobe from the clock-enable divider.
REQ-007 SHALL have port key_in  input  NUM_KEYS  debounced key levels, 1 = pressed.
REQ-008 SHALL have port key_press  output  NUM_KEYS  one-cycle pulse on press.
REQ-009 SHALL have port key_short  output  NUM_KEYS  one-cycle pulse on release before long threshold.
REQ-010 SHALL have port key_long  output  NUM_KEYS  one-cycle pulse when long threshold is reached.
REQ-011 SHALL have port key_rep  output  NUM_KEYS  one-cycle auto-repeat pulse while held past long.
REQ-012 SHALL have port key_held  output  NUM_KEYS  registered level, 1 while key is in a non-IDLE state.

Function
REQ-013 SHALL run one independent FSM per key with states IDLE, SHORT, LONG.
REQ-014 SHALL register key_in once; all edge detection SHALL use the registered and previous samples.
REQ-015 SHALL, when the sample goes 0->1 in IDLE, move to SHORT, clear the hold counter and assert key_press for exactly one clk in the next cycle.
REQ-016 SHALL increment the hold counter only on clk edges where en_tick=1 and the key is in SHORT or LONG.
REQ-017 SHALL, in SHORT, when the counter reaches LONG_TICKS-1 and en_tick=1 with the key still sampled 1, move to LONG, pulse key_long once and clear the counter.
REQ-018 SHALL, in LONG, pulse key_rep and clear the counter each time the counter reaches REPEAT_TICKS-1 on en_tick.
REQ-019 SHALL, on a 1->0 sample in SHORT, pulse key_short once and return to IDLE; in LONG it SHALL return to IDLE with no pulse.
REQ-020 SHALL give release priority over a threshold hit in the same cycle: no key_long or key_rep pulse, and key_short is pulsed if the state was SHORT.
REQ-021 SHALL size the counter as clog2(max(LONG_TICKS,REPEAT_TICKS)) bits, saturating and never wrapping.
REQ-022 SHALL drive all outputs from flops; latency from key_in change to pulse is 2 clk.
REQ-023 SHALL treat keys independently; simultaneous events on several keys SHALL all be reported in the same cycle.
REQ-024 SHALL not pulse any output twice for one event.

Reset
REQ-025 SHALL, on rst=1, asynchronously force all FSMs to IDLE, clear counters and sample registers, and drive key_press, key_short, key_long, key_rep and key_held to 0.
REQ-026 SHALL, if a key is held when rst deasserts, report key_press only after a fresh 0->1 sample.

Configuration
REQ-027 SHALL use macro KEY_AUTOREPEAT_EN: when defined, behave per REQ-018; when undefined, key_rep SHALL be tied to 0 and LONG SHALL hold without counting until release.

Structure
REQ-028 SHALL place the state encoding (IDLE=2'd0, SHORT=2'd1, LONG=2'd2) and the default LONG_TICKS and REPEAT_TICKS constants in shared package key_event_pkg.
REQ-029 SHALL implement one key's FSM and counter as sub-module key_event_fsm, instantiated NUM_KEYS times by a generate loop.

Verification
REQ-030 SHALL cover this case: key_in[0] pulse of 30 ticks -> key_press[0] once at +2 clk, key_short[0] once 2 clk after release, no key_long.
REQ-031 SHALL cover this case: key_in[1] held 250 ticks -> key_long[1] at tick 200, key_rep[1] at ticks 220 and 240, no key_short on release.
REQ-032 SHALL cover this case: release on the exact cycle of tick 200 -> key_short pulses and key_long stays 0.
REQ-033 SHALL cover this case: keys 0 and 3 pressed in the same cycle -> key_press = 4'b1001 in a single cycle.
REQ-034 SHALL cover this case: rst asserted mid-LONG -> all outputs 0 immediately; a key still held after rst gives no key_press until it is released and pressed again.
REQ-035 SHALL cover this case: build without KEY_AUTOREPEAT_EN, hold 300 ticks -> a single key_long and key_rep constantly 0.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event decoder: per-key state encoding,
// default timing constants and the hold-counter width helper.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } key_state_t;

  localparam int DEF_LONG_TICKS   = 200;
  localparam int DEF_REPEAT_TICKS = 20;

  // Counter only has to reach max(long, repeat) - 1; keep at least one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// One key channel: IDLE/SHORT/LONG state machine with a saturating hold counter.
// Auto-repeat in LONG is built only when KEY_AUTOREPEAT_EN is defined.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic en_tick,
  input  logic rise,
  input  logic fall,
  output logic press,
  output logic short_rel,
  output logic long_hit,
  output logic rep,
  output logic held
);

  localparam int CW = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TICKS - 1);
  logic rep_nxt;
`endif

  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          press_nxt, short_nxt, long_nxt;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      press     <= 1'b0;
      short_rel <= 1'b0;
      long_hit  <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      press     <= press_nxt;
      short_rel <= short_nxt;
      long_hit  <= long_nxt;
      held      <= (state_nxt != IDLE);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep <= 1'b0;
    else     rep <= rep_nxt;
  end
`else
  assign rep = 1'b0;
`endif

  // Release is tested before any threshold so a same-cycle release wins.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = SHORT;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      SHORT: begin
        if (fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else if (en_tick) begin
          if (cnt == LONG_LAST) begin
            state_nxt = LONG;
            cnt_nxt   = '0;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (en_tick) begin
          if (cnt == REP_LAST) begin
            cnt_nxt = '0;
            rep_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_event_decoder.sv
// Press / short / long / auto-repeat event decoder for NUM_KEYS debounced keys.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_tick,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_short,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_rep,
  output logic [NUM_KEYS-1:0] key_held
);

  logic [NUM_KEYS-1:0] samp, prev, armed, rise, fall;

  // armed stays low until a real 0 is seen on the key after reset, so a key
  // held through reset cannot produce a press until it is released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp  <= '0;
      prev  <= '0;
      armed <= '0;
    end else begin
      samp  <= key_in;
      prev  <= samp;
      armed <= armed | ~key_in;
    end
  end

  assign rise = samp & ~prev & armed;
  assign fall = prev & ~samp;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_event_fsm #(
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .en_tick   (en_tick),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .press     (key_press[g]),
      .short_rel (key_short[g]),
      .long_hit  (key_long[g]),
      .rep       (key_rep[g]),
      .held      (key_held[g])
    );
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed scenarios plus random
// traffic, all compared cycle by cycle against an event-level key model.
module tb_key_event_decoder;

  localparam int NK = 4;
  localparam int LT = 200;
  localparam int RT = 20;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int EXP_REP_250  = AR ? 2 : 0;
  localparam int EXP_REP0     = AR ? 220 : -1;
  localparam int EXP_REP1     = AR ? 240 : -1;
  localparam int EXP_REP_300  = AR ? (300 - LT) / RT : 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_tick = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_press, key_short, key_long, key_rep, key_held;

  int checks = 0;
  int errors = 0;

  // model: per key, the raw sample history since reset and the current press
  int            nsamp [NK];
  bit            cur   [NK];
  bit            old   [NK];
  bit            inp   [NK];
  bit            lseen [NK];
  int            ticks [NK];
  logic [NK-1:0] e_press, e_short, e_long, e_rep, e_held;

  key_event_decoder #(.NUM_KEYS(NK), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .en_tick(en_tick), .key_in(key_in),
    .key_press(key_press), .key_short(key_short), .key_long(key_long),
    .key_rep(key_rep), .key_held(key_held)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      nsamp[i] = 0; cur[i] = 0; old[i] = 0; inp[i] = 0; lseen[i] = 0; ticks[i] = 0;
    end
    e_press = '0; e_short = '0; e_long = '0; e_rep = '0; e_held = '0;
  endtask

  // A press is a 0 then 1 among real samples; ticks count from the press,
  // long at LT ticks, repeat every RT ticks after that, release checked first.
  task automatic model_step();
    e_press = '0; e_short = '0; e_long = '0; e_rep = '0;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NK; i++) begin
      if (inp[i]) begin
        if (!cur[i]) begin
          e_short[i] = !lseen[i];
          inp[i] = 1'b0;
        end else if (en_tick) begin
          ticks[i]++;
          if (!lseen[i] && ticks[i] == LT) begin
            e_long[i] = 1'b1;
            lseen[i] = 1'b1;
          end else if (AR && lseen[i] && ((ticks[i] - LT) % RT) == 0) begin
            e_rep[i] = 1'b1;
          end
        end
      end else if (nsamp[i] >= 2 && !old[i] && cur[i]) begin
        e_press[i] = 1'b1;
        inp[i] = 1'b1;
        ticks[i] = 0;
        lseen[i] = 1'b0;
      end
      e_held[i] = inp[i];
      old[i] = cur[i];
      cur[i] = key_in[i];
      if (nsamp[i] < 2) nsamp[i]++;
    end
  endtask

  // One clock: model sees the edge, new inputs go in after it, return at negedge.
  task automatic drive(input logic [NK-1:0] k, input logic t);
    @(posedge clk);
    model_step();
    #1;
    key_in  = k;
    en_tick = t;
    @(negedge clk);
  endtask

  task automatic test_reset();
    key_in = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      drive(4'b0100, 1'b0);
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got %h want 0", $time,
                 {key_press, key_short, key_long, key_rep, key_held});
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(c < 6 ? 4'b0100 : 4'b0000, c[0]);
      checks++;
      if ({key_press, key_short, key_held} !== 12'h0) begin
        errors++;
        $display("FAIL reset_held_key t=%0t got %h want 0", $time, {key_press, key_short, key_held});
      end
    end
  endtask

  task automatic test_short_press();
    int n_press = 0, n_short = 0, n_long = 0, press_at = -1, short_at = -1;
    logic t;
    for (int c = 0; c < 70; c++) begin
      t = (c >= 2 && c < 62 && (c % 2) == 0);
      drive(c < 62 ? 4'b0001 : 4'b0000, t);
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL short_model t=%0t got %h want %h", $time,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
      if (key_press[0]) begin n_press++; press_at = c; end
      if (key_short[0]) begin n_short++; short_at = c; end
      if (key_long[0]) n_long++;
    end
    checks += 5;
    if (n_press !== 1)   begin errors++; $display("FAIL short_press_count got %0d want 1", n_press); end
    if (press_at !== 2)  begin errors++; $display("FAIL short_press_latency got %0d want 2", press_at); end
    if (n_short !== 1)   begin errors++; $display("FAIL short_pulse_count got %0d want 1", n_short); end
    if (short_at !== 64) begin errors++; $display("FAIL short_pulse_latency got %0d want 64", short_at); end
    if (n_long !== 0)    begin errors++; $display("FAIL short_no_long got %0d want 0", n_long); end
  endtask

  task automatic test_long_repeat();
    int sent = 0, prev_sent, n_long = 0, long_tick = -1, n_rep = 0, n_short = 0;
    int rep_tick [2];
    logic t;
    rep_tick[0] = -1; rep_tick[1] = -1;
    for (int c = 0; c < 520; c++) begin
      t = (c >= 2 && (c % 2) == 0 && sent < 250);
      prev_sent = sent;
      drive(sent < 250 ? 4'b0010 : 4'b0000, t);
      if (t) sent++;
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL long_model t=%0t got %h want %h", $time,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
      if (key_long[1]) begin n_long++; long_tick = prev_sent; end
      if (key_rep[1]) begin
        if (n_rep < 2) rep_tick[n_rep] = prev_sent;
        n_rep++;
      end
      if (key_short[1]) n_short++;
    end
    checks += 6;
    if (n_long !== 1)             begin errors++; $display("FAIL long_count got %0d want 1", n_long); end
    if (long_tick !== LT)         begin errors++; $display("FAIL long_tick got %0d want %0d", long_tick, LT); end
    if (n_rep !== EXP_REP_250)    begin errors++; $display("FAIL rep_count got %0d want %0d", n_rep, EXP_REP_250); end
    if (rep_tick[0] !== EXP_REP0) begin errors++; $display("FAIL rep_tick0 got %0d want %0d", rep_tick[0], EXP_REP0); end
    if (rep_tick[1] !== EXP_REP1) begin errors++; $display("FAIL rep_tick1 got %0d want %0d", rep_tick[1], EXP_REP1); end
    if (n_short !== 0)            begin errors++; $display("FAIL long_no_short got %0d want 0", n_short); end
  endtask

  // late=0: release sample lands on the 200th tick; late=1: one cycle later.
  task automatic test_release_at_threshold();
    int n_short, n_long;
    for (int late = 0; late < 2; late++) begin
      n_short = 0; n_long = 0;
      drive(4'b0100, 1'b0);
      drive(4'b0100, 1'b0);
      for (int j = 0; j < LT - 1; j++) begin
        drive(4'b0100, 1'b1);
        drive(4'b0100, 1'b0);
        if (key_long[2]) n_long++;
      end
      for (int c = 0; c < 7; c++) begin
        if (c == 0)      drive(late != 0 ? 4'b0100 : 4'b0000, 1'b0);
        else if (c == 1) drive(4'b0000, 1'b1);
        else             drive(4'b0000, 1'b0);
        checks++;
        if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
          errors++;
          $display("FAIL thresh_model late=%0d t=%0t got %h want %h", late, $time,
                   {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
        end
        if (key_short[2]) n_short++;
        if (key_long[2]) n_long++;
      end
      checks += 2;
      if (n_short !== 1 - late) begin errors++; $display("FAIL thresh_short late=%0d got %0d want %0d", late, n_short, 1 - late); end
      if (n_long !== late)      begin errors++; $display("FAIL thresh_long late=%0d got %0d want %0d", late, n_long, late); end
    end
  endtask

  task automatic test_simultaneous();
    int n_press = 0, n_short = 0;
    logic [NK-1:0] pv = '0, sv = '0;
    for (int c = 0; c < 10; c++) begin
      drive(c < 6 ? 4'b1001 : 4'b0000, 1'b0);
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL simul_model t=%0t got %h want %h", $time,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
      if (key_press != '0) begin n_press++; pv = key_press; end
      if (key_short != '0) begin n_short++; sv = key_short; end
    end
    checks += 4;
    if (n_press !== 1)    begin errors++; $display("FAIL simul_press_cycles got %0d want 1", n_press); end
    if (pv !== 4'b1001)   begin errors++; $display("FAIL simul_press_value got %b want 1001", pv); end
    if (n_short !== 1)    begin errors++; $display("FAIL simul_short_cycles got %0d want 1", n_short); end
    if (sv !== 4'b1001)   begin errors++; $display("FAIL simul_short_value got %b want 1001", sv); end
  endtask

  task automatic test_reset_mid_long();
    int n_long = 0, n_press = 0;
    drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b0);
    for (int c = 0; c < LT + 3; c++) begin
      drive(4'b0010, c < LT);
      if (key_long[1]) n_long++;
    end
    checks += 2;
    if (n_long !== 1)      begin errors++; $display("FAIL rstlong_reached got %0d want 1", n_long); end
    if (key_held !== 4'b0010) begin errors++; $display("FAIL rstlong_held got %b want 0010", key_held); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({key_press, key_short, key_long, key_rep, key_held} !== 20'h0) begin
      errors++;
      $display("FAIL rstlong_async got %h want 0", {key_press, key_short, key_long, key_rep, key_held});
    end
    for (int c = 0; c < 3; c++) drive(4'b0010, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010, 1'($urandom_range(0, 1)));
      if (key_press[1]) n_press++;
    end
    checks++;
    if (n_press !== 0) begin errors++; $display("FAIL rstlong_no_press got %0d want 0", n_press); end
    for (int c = 0; c < 10; c++) begin
      drive(c < 3 ? 4'b0000 : (c < 7 ? 4'b0010 : 4'b0000), 1'b0);
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL rstlong_model t=%0t got %h want %h", $time,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
      if (key_press[1]) n_press++;
    end
    checks++;
    if (n_press !== 1) begin errors++; $display("FAIL rstlong_repress got %0d want 1", n_press); end
  endtask

  task automatic test_no_autorepeat();
    int n_long = 0, n_rep = 0;
    drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    for (int c = 0; c < 310; c++) begin
      drive(c < 305 ? 4'b0001 : 4'b0000, c < 300);
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL norep_model t=%0t got %h want %h", $time,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
      if (key_long[0]) n_long++;
      if (key_rep != '0) n_rep++;
    end
    checks += 2;
    if (n_long !== 1)          begin errors++; $display("FAIL norep_long got %0d want 1", n_long); end
    if (n_rep !== EXP_REP_300) begin errors++; $display("FAIL norep_rep got %0d want %0d", n_rep, EXP_REP_300); end
  endtask

  task automatic test_random();
    logic [NK-1:0] k;
    int slow;
    k = key_in;
    for (int c = 0; c < 3000; c++) begin
      slow = (c >= 1200) ? 250 : 12;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, slow - 1) == 0) k[i] = ~k[i];
      if (c == 2000) begin
        rst = 1'b1;
        model_reset();
      end
      if (c == 2003) rst = 1'b0;
      drive(k, ($urandom_range(0, 3) != 0));
      checks++;
      if ({key_press, key_short, key_long, key_rep, key_held} !== {e_press, e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL random_model c=%0d got %h want %h", c,
                 {key_press, key_short, key_long, key_rep, key_held}, {e_press, e_short, e_long, e_rep, e_held});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_threshold();
    test_simultaneous();
    test_reset_mid_long();
    test_no_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
